// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf -- elastic inter-stage register for the five-stage datapath.
//
// Carries NUM_FIELDS packed fields of DATA_W bits (field 0 = IR) between two
// pipeline stages. Uses a valid/ready handshake with a two-entry main/skid
// buffer, so in_ready comes from a register and never from out_ready. A
// synchronous flush squashes held beats to the all-zero NOP. A saturating
// counter tracks back-pressured cycles.
//
// Ports
//   Clk        : clock, rising edge
//   Reset      : synchronous, active high, highest priority
//   flush      : squash all held beats (overrides accept/drain)
//   in_valid   : upstream beat present
//   in_ready   : stage can accept (registered, = !skid_valid)
//   in_data    : NUM_FIELDS*DATA_W packed fields, field k at [k*DATA_W +: DATA_W]
//   out_valid  : head beat valid
//   out_ready  : downstream takes head beat
//   out_data   : head beat (all zero when not valid)
//   occupancy  : beats held, 0..2
//   stall_cnt  : cycles with out_valid & !out_ready, saturating

// Per-field storage slice: one main and one skid register for one field.
// The control strobes come from the shared FSM in the top level. Clears take
// precedence so that an entry going invalid always reads back as zero.
module pipe_stage_buf_field #(
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              main_ld_in,
  input  logic              main_ld_skid,
  input  logic              main_clr,
  input  logic              skid_ld_in,
  input  logic              skid_clr,
  input  logic [DATA_W-1:0] in_field,
  output logic [DATA_W-1:0] main_q,
  output logic [DATA_W-1:0] skid_q
);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (main_clr)          main_q <= '0;
      else if (main_ld_skid) main_q <= skid_q;
      else if (main_ld_in)   main_q <= in_field;

      if (skid_clr)          skid_q <= '0;
      else if (skid_ld_in)   skid_q <= in_field;
    end
  end

endmodule

module pipe_stage_buf #(
  parameter int DATA_W     = 32,
  parameter int NUM_FIELDS = 5,
  parameter int CNT_W      = 16
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_FIELDS*DATA_W-1:0] out_data,
  output logic [1:0]                   occupancy,
  output logic [CNT_W-1:0]             stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state_q, state_d;

  logic main_valid, skid_valid;
  logic accept, drain;

  // Data-path strobes shared by every field slice
  logic main_ld_in, main_ld_skid, main_clr;
  logic skid_ld_in, skid_clr;

  logic [NUM_FIELDS-1:0][DATA_W-1:0] in_fields;
  logic [NUM_FIELDS-1:0][DATA_W-1:0] main_data;
  logic [NUM_FIELDS-1:0][DATA_W-1:0] skid_data;

  // Valid bits are decoded from the state register. This keeps in_ready
  // purely registered, with no out_ready -> in_ready combinational path.
  assign main_valid = (state_q != EMPTY);
  assign skid_valid = (state_q == FULL);

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign accept    = in_valid  && in_ready;
  assign drain     = out_valid && out_ready;

  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  assign in_fields = in_data;
  assign out_data  = main_data;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Next-state and data-path strobes
  always_comb begin
    state_d      = state_q;
    main_ld_in   = 1'b0;
    main_ld_skid = 1'b0;
    main_clr     = 1'b0;
    skid_ld_in   = 1'b0;
    skid_clr     = 1'b0;

    if (flush) begin
      // Flush discards everything, including a beat handshaken this cycle
      state_d  = EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d    = ONE;
            main_ld_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_ld_in = 1'b1;
          end else if (accept) begin
            state_d    = FULL;
            skid_ld_in = 1'b1;
          end else if (drain) begin
            state_d  = EMPTY;
            main_clr = 1'b1;
          end
        end
        FULL: begin
          // in_ready is low here, so only a drain can move the state
          if (drain) begin
            state_d      = ONE;
            main_ld_skid = 1'b1;
            skid_clr     = 1'b1;
          end
        end
        default: begin
          state_d  = EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  // One storage slice per field
  for (genvar k = 0; k < NUM_FIELDS; k++) begin : g_field
    pipe_stage_buf_field #(.DATA_W(DATA_W)) u_field (
      .Clk          (Clk),
      .Reset        (Reset),
      .main_ld_in   (main_ld_in),
      .main_ld_skid (main_ld_skid),
      .main_clr     (main_clr),
      .skid_ld_in   (skid_ld_in),
      .skid_clr     (skid_clr),
      .in_field     (in_fields[k]),
      .main_q       (main_data[k]),
      .skid_q       (skid_data[k])
    );
  end

  // Back-pressure counter. Only Reset clears it; flush leaves it alone so
  // that stall history survives pipeline squashes.
  always_ff @(posedge Clk) begin
    if (Reset)
      stall_cnt <= '0;
    else if (main_valid && !out_ready && (stall_cnt != CNT_MAX))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

  localparam int DATA_W     = 32;
  localparam int NUM_FIELDS = 5;
  localparam int CNT_W      = 4;
  localparam int BUS_W      = DATA_W * NUM_FIELDS;

  logic             Clk = 1'b0;
  logic             Reset, flush, in_valid, out_ready;
  logic             in_ready, out_valid;
  logic [BUS_W-1:0] in_data, out_data;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  pipe_stage_buf #(.DATA_W(DATA_W), .NUM_FIELDS(NUM_FIELDS), .CNT_W(CNT_W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  always #5 Clk = ~Clk;

  // Field 0 carries v; the other fields get distinct derived patterns so
  // that a field mix-up shows as a data error.
  function automatic logic [BUS_W-1:0] mk(input logic [31:0] v);
    logic [BUS_W-1:0] r;
    for (int k = 0; k < NUM_FIELDS; k++)
      r[k*DATA_W +: DATA_W] = v ^ (32'(k) * 32'h0101_0000);
    return r;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic [CNT_W-1:0] cnt);
    chk({tag, ".out_valid"}, BUS_W'(out_valid), BUS_W'(0));
    chk({tag, ".out_data"},  out_data,           '0);
    chk({tag, ".in_ready"},  BUS_W'(in_ready),  BUS_W'(1));
    chk({tag, ".occupancy"}, BUS_W'(occupancy), BUS_W'(0));
    chk({tag, ".stall_cnt"}, BUS_W'(stall_cnt), BUS_W'(cnt));
  endtask

  // skid_valid must never be set without main_valid
  always @(negedge Clk) begin
    if (!Reset) begin
      assert (!(dut.skid_valid && !dut.main_valid)) else begin
        n_fail++;
        $error("FAIL invariant: skid_valid=%0b main_valid=%0b", dut.skid_valid, dut.main_valid);
      end
    end
  end

  initial begin
    Reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

    // Reset
    tick(); tick();
    chk_idle("reset", 4'd0);
    Reset = 1'b0;

    // Streaming at full rate
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; in_data = mk(32'(i));
      tick();
      chk($sformatf("stream%0d.out_valid", i), BUS_W'(out_valid), BUS_W'(1));
      chk($sformatf("stream%0d.out_data", i),  out_data,           mk(32'(i)));
      chk($sformatf("stream%0d.occupancy", i), BUS_W'(occupancy), BUS_W'(1));
    end
    in_valid = 1'b0; in_data = '0;
    tick();
    chk_idle("stream_end", 4'd0);

    // Back-pressure: A, B accepted, C held upstream
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = mk(32'h11);
    tick();
    chk("bp_a.out_data", out_data, mk(32'h11));
    chk("bp_a.stall",    BUS_W'(stall_cnt), BUS_W'(0));
    in_data = mk(32'h22);
    tick();
    chk("bp_b.in_ready",  BUS_W'(in_ready),  BUS_W'(0));
    chk("bp_b.occupancy", BUS_W'(occupancy), BUS_W'(2));
    chk("bp_b.out_data",  out_data,           mk(32'h11));
    chk("bp_b.stall",     BUS_W'(stall_cnt), BUS_W'(1));
    in_data = mk(32'h33);
    tick();
    chk("bp_c0.out_data", out_data, mk(32'h11));
    chk("bp_c0.stall",    BUS_W'(stall_cnt), BUS_W'(2));
    tick();
    chk("bp_c1.in_ready", BUS_W'(in_ready),  BUS_W'(0));
    chk("bp_c1.stall",    BUS_W'(stall_cnt), BUS_W'(3));
    out_ready = 1'b1;
    tick();
    chk("bp_drain1.out_data",  out_data,           mk(32'h22));
    chk("bp_drain1.occupancy", BUS_W'(occupancy), BUS_W'(1));
    chk("bp_drain1.in_ready",  BUS_W'(in_ready),  BUS_W'(1));
    tick();
    chk("bp_drain2.out_data",  out_data,           mk(32'h33));
    chk("bp_drain2.occupancy", BUS_W'(occupancy), BUS_W'(1));
    in_valid = 1'b0; in_data = '0;
    tick();
    chk_idle("bp_end", 4'd3);

    // Flush while FULL with in_valid high
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = mk(32'h44);
    tick();
    in_data = mk(32'h55);
    tick();
    chk("fl_full.occupancy", BUS_W'(occupancy), BUS_W'(2));
    flush = 1'b1; in_data = mk(32'h66);
    tick();
    chk_idle("fl_full", 4'd5);
    flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick();
    chk_idle("fl_full_after", 4'd5);

    // Flush in ONE with a real handshake on the flush cycle
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = mk(32'h77);
    tick();
    flush = 1'b1; in_data = mk(32'h88);
    tick();
    chk_idle("fl_one", 4'd6);
    flush = 1'b0; in_valid = 1'b0; in_data = '0;
    tick();
    chk_idle("fl_one_after", 4'd6);

    // Drain to empty leaves the NOP bubble
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = mk(32'hDEAD_BEEF);
    tick();
    chk("nop.beat", out_data, mk(32'hDEAD_BEEF));
    in_valid = 1'b0; in_data = '0;
    tick();
    chk_idle("nop.bubble", 4'd6);

    // Reset while FULL with stall_cnt at 7
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = mk(32'h99);
    tick();
    in_data = mk(32'hAA);
    tick();
    chk("rst_full.stall",     BUS_W'(stall_cnt), BUS_W'(7));
    chk("rst_full.occupancy", BUS_W'(occupancy), BUS_W'(2));
    Reset = 1'b1; in_valid = 1'b0; in_data = '0;
    tick();
    chk_idle("rst_full", 4'd0);
    Reset = 1'b0;

    // Counter saturation at 15 for a 4-bit counter
    in_valid = 1'b1; in_data = mk(32'hBB);
    tick();
    in_valid = 1'b0; in_data = '0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 14) chk("sat14", BUS_W'(stall_cnt), BUS_W'(14));
      if (k == 15) chk("sat15", BUS_W'(stall_cnt), BUS_W'(15));
    end
    chk("sat20.stall",     BUS_W'(stall_cnt), BUS_W'(15));
    chk("sat20.out_valid", BUS_W'(out_valid), BUS_W'(1));
    chk("sat20.out_data",  out_data,           mk(32'hBB));
    out_ready = 1'b1;
    tick();
    chk_idle("sat_end", 4'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
